// File: rtl/rv_core_pkg.sv
// Core-wide constants shared by the front end, plus the fetch queue entry layout.
package rv_core_pkg;

    localparam int unsigned     XLEN        = 32;
    localparam logic [XLEN-1:0] RV_RESET_PC = 32'd0;
    localparam logic [XLEN-1:0] RV_NOP      = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of {pc, instr} entries; flush empties it in one cycle.
module fetch_fifo
    import rv_core_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  fetch_entry_t                 push_data_i,
    input  logic                         pop_i,
    output fetch_entry_t                 head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !flush_i && (count_q != '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: credit-limited in-order requests into a prefetch
// queue, with redirect flushing and counted discard of stale responses.
module instr_fetch_unit
    import rv_core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RV_RESET_PC,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   in_flight_q, in_flight_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   queued;
    logic            accept;
    logic            rsp_fire;
    logic            push;
    logic            pop;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    // A slot is reserved for every outstanding request so no response is ever dropped.
    assign imem_req_valid = !reset && ((SW'(queued) + SW'(in_flight_q)) < SW'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign out_valid      = (queued != '0);
    assign out_instr      = out_valid ? head.instr : '0;
    assign out_pc         = out_valid ? head.pc : '0;

    // Live responses return in order from the last restart point, so their pc is a running count.
    assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};

    always_comb begin
        accept      = imem_req_valid && imem_req_ready;
        rsp_fire    = imem_rsp_valid && (in_flight_q != '0);
        pop         = out_valid && out_ready;
        push        = rsp_fire && (discard_q == '0) && !redirect_valid;
        in_flight_d = in_flight_q + CW'(accept) - CW'(rsp_fire);
        fetch_pc_d  = fetch_pc_q + XLEN'(accept);
        rsp_pc_d    = rsp_pc_q + XLEN'(push);
        discard_d   = discard_q;
        if (rsp_fire && (discard_q != '0)) discard_d = discard_q - CW'(1);
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            discard_d  = in_flight_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q  <= RESET_PC;
            rsp_pc_q    <= RESET_PC;
            in_flight_q <= '0;
            discard_q   <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            rsp_pc_q    <= rsp_pc_d;
            in_flight_q <= in_flight_d;
            discard_q   <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (redirect_valid),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (queued)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: queue-based reference model plus directed literal checks.
module tb_instr_fetch_unit;

    localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFFE;
    localparam int          DEPTH       = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready = 1'b0;

    instr_fetch_unit #(
        .RESET_PC (TB_RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Stimulus intent for the next cycle.
    logic        t_rst = 1'b1, t_rdy = 1'b0, t_ordy = 1'b0, t_redir = 1'b0;
    logic [31:0] t_rpc = '0;
    int          lat_lo = 1, lat_hi = 1;
    bit          spur_en = 1'b0;

    // Reference model: queued pcs, in-flight pcs with stale tags, next fetch address.
    logic [31:0] mq_pc[$];
    logic [31:0] fl_pc[$];
    bit          fl_st[$];
    logic [31:0] m_pc = TB_RESET_PC;

    // Memory environment: accepted addresses and the cycle each may return.
    logic [31:0] pend_a[$];
    int          pend_r[$];
    bit          d_real;

    // Observations used by directed checks.
    logic        s_req_v, s_out_v;
    logic [31:0] s_req_a, s_out_pc, s_out_instr;
    logic [31:0] popped[$];
    logic [31:0] acc_log[$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0013;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic compare();
        logic exp_rv;
        exp_rv = !t_rst && ((mq_pc.size() + fl_pc.size()) < DEPTH);
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
        chk("out_valid", 32'(out_valid), 32'(mq_pc.size() > 0));
        if (mq_pc.size() > 0) begin
            chk("out_pc", out_pc, mq_pc[0]);
            chk("out_instr", out_instr, instr_of(mq_pc[0]));
        end else if (t_rst) begin
            chk("reset out_pc", out_pc, 32'h0);
            chk("reset out_instr", out_instr, 32'h0);
        end
    endtask

    task automatic model_update();
        bit          acc, rsp, popv, st;
        logic [31:0] p;
        st = 1'b0;
        p  = '0;
        if (t_rst) begin
            mq_pc.delete();
            fl_pc.delete();
            fl_st.delete();
            m_pc = TB_RESET_PC;
            return;
        end
        acc  = ((mq_pc.size() + fl_pc.size()) < DEPTH) && t_rdy;
        rsp  = imem_rsp_valid && (fl_pc.size() > 0);
        popv = (mq_pc.size() > 0) && t_ordy;
        if (rsp) begin
            p  = fl_pc.pop_front();
            st = fl_st.pop_front();
        end
        if (acc) begin
            fl_pc.push_back(m_pc);
            fl_st.push_back(1'b0);
            m_pc = m_pc + 32'd1;
        end
        if (t_redir) begin
            mq_pc.delete();
            foreach (fl_st[i]) fl_st[i] = 1'b1;
            m_pc = t_rpc;
        end else begin
            if (popv) void'(mq_pc.pop_front());
            if (rsp && !st) mq_pc.push_back(p);
        end
    endtask

    task automatic env_update();
        if (t_rst) begin
            pend_a.delete();
            pend_r.delete();
            return;
        end
        if (imem_rsp_valid && d_real) begin
            void'(pend_a.pop_front());
            void'(pend_r.pop_front());
        end
        if (s_req_v && t_rdy) begin
            pend_a.push_back(s_req_a);
            pend_r.push_back(cyc + $urandom_range(lat_hi, lat_lo));
        end
    endtask

    task automatic run_cycle();
        @(negedge clk);
        d_real         = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (pend_a.size() > 0 && pend_r[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            d_real         = 1'b1;
            imem_rsp_data  = instr_of(pend_a[0]);
        end else if (spur_en && !t_rst && pend_a.size() == 0 && $urandom_range(7, 0) == 0) begin
            imem_rsp_valid = 1'b1;
        end
        reset          = t_rst;
        imem_req_ready = t_rdy;
        out_ready      = t_ordy;
        redirect_valid = t_redir;
        redirect_pc    = t_rpc;
        #1;
        compare();
        s_req_v     = imem_req_valid;
        s_req_a     = imem_req_addr;
        s_out_v     = out_valid;
        s_out_pc    = out_pc;
        s_out_instr = out_instr;
        if (!t_rst && s_out_v && t_ordy) popped.push_back(s_out_pc);
        if (!t_rst && s_req_v && t_rdy) acc_log.push_back(s_req_a);
        @(posedge clk);
        model_update();
        env_update();
        cyc++;
    endtask

    task automatic set_in(input logic rst, input logic rdy, input logic ordy);
        t_rst   = rst;
        t_rdy   = rdy;
        t_ordy  = ordy;
        t_redir = 1'b0;
    endtask

    task automatic do_reset(input int n);
        set_in(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset and back-to-back streaming with 1-cycle memory (addresses wrap past 0).
        lat_lo = 1; lat_hi = 1;
        do_reset(3);
        set_in(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++) begin
            run_cycle();
            if (k < 4) begin
                chk("stream req_valid", 32'(s_req_v), 32'd1);
                chk("stream req_addr", s_req_a, TB_RESET_PC + 32'(k));
            end
            if (k >= 2) begin
                chk("stream out_valid", 32'(s_out_v), 32'd1);
                chk("stream out_pc", s_out_pc, TB_RESET_PC + 32'(k - 2));
            end
        end

        // Decode stalled: credits cap accepted requests at DEPTH.
        do_reset(2);
        acc_log.delete();
        set_in(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 12; k++) run_cycle();
        chk("stall accepted count", 32'(acc_log.size()), 32'(DEPTH));
        chk("stall req_valid low", 32'(s_req_v), 32'd0);
        acc_log.delete();
        popped.delete();
        set_in(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) run_cycle();
        if (popped.size() >= 4) begin
            for (int k = 0; k < 4; k++) chk("release pop order", popped[k], TB_RESET_PC + 32'(k));
        end else chk("release pop count", 32'(popped.size()), 32'd4);
        if (acc_log.size() > 0) chk("resume addr", acc_log[0], TB_RESET_PC + 32'd4);
        else chk("resume accepted", 32'(acc_log.size()), 32'd1);

        // Redirect with two requests in flight.
        lat_lo = 3; lat_hi = 3;
        do_reset(2);
        set_in(1'b0, 1'b1, 1'b1);
        run_cycle();
        run_cycle();
        set_in(1'b0, 1'b0, 1'b1);
        t_redir = 1'b1;
        t_rpc   = 32'h40;
        run_cycle();
        popped.delete();
        set_in(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 14; k++) run_cycle();
        if (popped.size() >= 2) begin
            chk("redirect first pc", popped[0], 32'h40);
            chk("redirect second pc", popped[1], 32'h41);
        end else chk("redirect pop count", 32'(popped.size()), 32'd2);

        // Redirect coinciding with a response and a pop.
        lat_lo = 1; lat_hi = 1;
        do_reset(2);
        set_in(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++) run_cycle();
        t_redir = 1'b1;
        t_rpc   = 32'h200;
        run_cycle();
        chk("redir cycle out_valid", 32'(s_out_v), 32'd1);
        popped.delete();
        set_in(1'b0, 1'b1, 1'b1);
        run_cycle();
        chk("after redir out_valid", 32'(s_out_v), 32'd0);
        for (int k = 0; k < 8; k++) run_cycle();
        if (popped.size() >= 1) chk("after redir first pc", popped[0], 32'h200);
        else chk("after redir pop count", 32'(popped.size()), 32'd1);

        // Randomized traffic: ready, latency, decode back-pressure, redirects, rare resets.
        lat_lo = 1; lat_hi = 5;
        spur_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            t_rst   = ($urandom_range(499, 0) == 0);
            t_rdy   = ($urandom_range(3, 0) != 0);
            t_ordy  = ($urandom_range(9, 0) < 7);
            t_redir = !t_rst && ($urandom_range(39, 0) == 0);
            t_rpc   = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFD : 32'($urandom);
            run_cycle();
        end
        spur_en = 1'b0;

        // Reset while the queue is full.
        lat_lo = 1; lat_hi = 1;
        do_reset(2);
        set_in(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) run_cycle();
        chk("full before reset", 32'(s_out_v), 32'd1);
        do_reset(2);
        chk("reset out_valid", 32'(s_out_v), 32'd0);
        chk("reset out_pc", s_out_pc, 32'h0);
        chk("reset out_instr", s_out_instr, 32'h0);
        chk("reset req_valid", 32'(s_req_v), 32'd0);
        set_in(1'b0, 1'b1, 1'b1);
        run_cycle();
        chk("post-reset req_valid", 32'(s_req_v), 32'd1);
        chk("post-reset req_addr", s_req_a, TB_RESET_PC);
        for (int k = 0; k < 6; k++) run_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'd0: word address fetched first after reset.
REQ-002 SHALL have parameter DEPTH, default 4: prefetch queue entries; power of two, 2..16.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port redirect_valid  input  1: taken branch/jump; restart fetch at redirect_pc.
REQ-006 SHALL have port redirect_pc  input  32: new word address.
REQ-007 SHALL have port imem_req_valid  output  1: fetch request to instruction memory.
REQ-008 SHALL have port imem_req_addr  output  32: word address of the request.
REQ-009 SHALL have port imem_req_ready  input  1: memory accepts the request this cycle.
REQ-010 SHALL have port imem_rsp_valid  input  1: instruction word returned.
REQ-011 SHALL have port imem_rsp_data  input  32: returned instruction.
REQ-012 SHALL have port out_valid  output  1: instruction available to decode/control.
REQ-013 SHALL have port out_instr  output  32: instruction at queue head.
REQ-014 SHALL have port out_pc  output  32: word address of out_instr.
REQ-015 SHALL have port out_ready  input  1: decode consumes the head this cycle.

Function
REQ-016 SHALL address memory in words; sequential fetch_pc advance is +1, wrapping 32'hFFFFFFFF -> 0.
REQ-017 SHALL accept a request on imem_req_valid && imem_req_ready; fetch_pc advances by 1 that cycle.
REQ-018 SHALL assert imem_req_valid only when queued + in_flight < DEPTH (no response may ever be dropped for lack of space).
REQ-019 SHALL hold imem_req_valid and imem_req_addr stable until accepted, except when withdrawn or re-addressed by redirect.
REQ-020 SHALL treat responses as in order, arriving at least one cycle after acceptance; in_flight counts accepted-minus-returned, range 0..DEPTH.
REQ-021 SHALL write each non-stale response with its request address into the queue; out_valid rises the cycle after the response (no bypass).
REQ-022 SHALL drive out_valid = queue non-empty; out_instr/out_pc from the head; pop on out_valid && out_ready.
REQ-023 SHALL allow push and pop in the same cycle, including when the queue is full.
REQ-024 SHALL on redirect_valid: empty the queue, set fetch_pc = redirect_pc, set discard = in_flight (including any request accepted that cycle); out_valid is 0 the next cycle.
REQ-025 SHALL drop the next discard responses (decrementing discard), including any arriving in the redirect cycle itself; none reach the queue.
REQ-026 SHALL give redirect priority over pop/push in the same cycle; a pop coinciding with redirect counts as consumed.
REQ-027 SHALL allow a request for redirect_pc in the cycle after redirect, even while discard > 0, subject to REQ-018.
REQ-028 SHALL ignore imem_rsp_valid when in_flight == 0.
REQ-029 SHALL hold the queue unchanged while out_ready is low; requests stop once credits are exhausted.

Reset
REQ-030 SHALL, while reset is high, set fetch_pc = RESET_PC; queue, in_flight and discard = 0; imem_req_valid = 0; out_valid = 0; out_instr = 0; out_pc = 0.
REQ-031 SHALL discard, after reset, no responses to pre-reset requests; memory is reset together with this block.
REQ-032 SHALL issue the first request (addr RESET_PC) no earlier than the first cycle after reset deasserts.

Structure
REQ-033 SHALL take XLEN=32, RESET_PC default and the NOP encoding 32'h00000013 from shared package rv_core_pkg.
REQ-034 SHALL implement the queue as sub-module fetch_fifo (synchronous FIFO, parameter DEPTH, flush input, 64-bit entry {pc, instr}).

Verification
REQ-035 Reset, memory ready always, 1-cycle latency, out_ready=1 -> requests 0,1,2,3 on consecutive cycles; out_pc 0,1,2,... every cycle from cycle 2.
REQ-036 out_ready=0 held, DEPTH=4 -> exactly 4 requests accepted, imem_req_valid low afterwards; release -> pops in order 0..3, fetching resumes at 4.
REQ-037 Redirect to 32'h40 with 2 requests in flight -> both responses dropped, out_pc next valid = 32'h40, then 32'h41.
REQ-038 Redirect in the same cycle as a response and a pop -> queue empty next cycle, response not visible, discard decremented.
REQ-039 Random imem_req_ready/latency 1..5 with random out_ready -> out_pc sequence strictly +1 between redirects, no loss, no duplicates.
REQ-040 Reset asserted mid-stream with full queue -> all outputs zero next cycle; first post-reset request addr = RESET_PC.
